// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Canonical NOP (addi x0,x0,0), also used to initialise the instruction memory.
  localparam logic [31:0] NOP = 32'h0000_0013;

  localparam int IMEM_DEPTH = 1024;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream program loader: packs bytes little-endian into words and writes
// them to the instruction memory while holding the core in reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [LW-1:0] len_i,
  input  logic          abort_i,
  input  logic          rx_valid_i,
  input  logic [7:0]    rx_data_i,
  output logic          rx_ready_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_waddr_o,
  output logic [31:0]   mem_wdata_o,
  output logic          core_hold_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o
);

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  state_e        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic          err_q, err_d;

  logic [LW-1:0] len_clamped;
  logic [LW-1:0] cnt_inc;

  assign len_clamped = (len_i > DEPTH_L) ? DEPTH_L : len_i;
  assign cnt_inc     = cnt_q + ONE_L;

  always_comb begin
    // NOTE: every next-state signal takes its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          len_d   = len_clamped;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = (len_clamped == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (rx_valid_i) begin
          // Shifting in from the top leaves byte 0 in [7:0] after four bytes.
          word_d = {rx_data_i, word_q[31:8]};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_inc;
        idx_d = '0;
        if (abort_i) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (cnt_inc == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RECV;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  assign rx_ready_o  = (state_q == ST_RECV);
  assign mem_we_o    = (state_q == ST_WRITE);
  assign mem_waddr_o = cnt_q[AW-1:0];
  assign mem_wdata_o = word_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign core_hold_o = busy_o;
  assign done_o      = (state_q == ST_DONE);
  assign err_o       = err_q;

endmodule
